// File: rtl/lsu_pkg.sv
// Shared load-store unit types: store buffer entry layout and bank-select field position.
package lsu_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } stb_entry_t;

  localparam int LSU_BANK_SEL_W   = 3;
  localparam int LSU_BANK_SEL_LSB = 2;

endpackage

// File: rtl/lsu_stb_fwd_merge.sv
// Store-to-load forwarding merge: per byte lane, picks the youngest matching entry.
// Only instantiated when LSU_STB_FWD_EN is defined.
module lsu_stb_fwd_merge
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  stb_entry_t                   entries [DEPTH],
  input  logic [DEPTH-1:0]             valid,
  input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
  input  logic                         ld_valid,
  input  logic [31:0]                  ld_addr,
  output logic                         hit,
  output logic [31:0]                  data,
  output logic [3:0]                   be
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] idx;
  logic             unused_ld_lsb;

  assign unused_ld_lsb = ^ld_addr[1:0];

  // Walk oldest to youngest so later matches overwrite earlier ones lane by lane.
  always_comb begin
    data = '0;
    be   = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (ld_valid && valid[idx] && (entries[idx].addr[31:2] == ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (entries[idx].be[b]) begin
            data[8*b +: 8] = entries[idx].data[8*b +: 8];
            be[b]          = 1'b1;
          end
        end
      end
    end
  end

  assign hit = |be;

endmodule

// File: rtl/lsu_store_buffer.sv
// In-order committed-store buffer draining one entry per cycle to the bank-write stage.
// Optional store-to-load forwarding compiled in with LSU_STB_FWD_EN.
//
// state       | meaning
// OCC_EMPTY   | count = 0, nothing to drain
// OCC_PARTIAL | 0 < count < DEPTH, push and pop both allowed
// OCC_FULL    | count = DEPTH, pushes stalled
module lsu_store_buffer
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       st_valid_i,
  output logic                       st_ready_o,
  input  logic [31:0]                st_addr_i,
  input  logic [31:0]                st_data_i,
  input  logic [3:0]                 st_be_i,
  output logic                       mem_valid_o,
  input  logic                       mem_ready_i,
  output logic [31:0]                mem_addr_o,
  output logic [31:0]                mem_data_o,
  output logic [3:0]                 mem_be_o,
  output logic [2:0]                 mem_sel_o,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o,
  input  logic                       ld_valid_i,
  input  logic [31:0]                ld_addr_i,
  output logic                       fwd_hit_o,
  output logic [31:0]                fwd_data_o,
  output logic [3:0]                 fwd_be_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] OCC_EMPTY   = 2'd0;
  localparam logic [1:0] OCC_PARTIAL = 2'd1;
  localparam logic [1:0] OCC_FULL    = 2'd2;

  stb_entry_t       entries [DEPTH];
  stb_entry_t       head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       occ_state;
  logic             push;
  logic             pop;

  always_comb begin
    occ_state = OCC_PARTIAL;
    if (count == '0)
      occ_state = OCC_EMPTY;
    else if (count == CNT_W'(DEPTH))
      occ_state = OCC_FULL;
  end

  assign empty_o     = (occ_state == OCC_EMPTY);
  assign full_o      = (occ_state == OCC_FULL);
  assign count_o     = count;
  assign st_ready_o  = ~full_o & ~flush_i;
  assign mem_valid_o = ~empty_o;
  assign push        = st_valid_i & st_ready_o;
  assign pop         = mem_valid_o & mem_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push)
      entries[wr_ptr] <= '{addr: st_addr_i, data: st_data_i, be: st_be_i};
  end

  always_comb begin
    head = '0;
    if (!empty_o)
      head = entries[rd_ptr];
  end

  assign mem_addr_o = head.addr;
  assign mem_data_o = head.data;
  assign mem_be_o   = head.be;
  assign mem_sel_o  = head.addr[LSU_BANK_SEL_LSB +: LSU_BANK_SEL_W];

`ifdef LSU_STB_FWD_EN
  logic [DEPTH-1:0] valid_mask;
  logic [PTR_W-1:0] age;

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    valid_mask = '0;
    age        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age           = PTR_W'(i) - rd_ptr;
      valid_mask[i] = ({1'b0, age} < count);
    end
  end

  lsu_stb_fwd_merge #(.DEPTH(DEPTH)) u_fwd_merge (
    .entries  (entries),
    .valid    (valid_mask),
    .rd_ptr   (rd_ptr),
    .ld_valid (ld_valid_i),
    .ld_addr  (ld_addr_i),
    .hit      (fwd_hit_o),
    .data     (fwd_data_o),
    .be       (fwd_be_o)
  );
`else
  logic unused_ld;

  assign unused_ld  = ld_valid_i ^ (^ld_addr_i);
  assign fwd_hit_o  = 1'b0;
  assign fwd_data_o = '0;
  assign fwd_be_o   = '0;
`endif

endmodule

// File: tb/tb_lsu_store_buffer.sv
// Self-checking bench for lsu_store_buffer: directed vector table plus randomized run
// against a queue-based reference model.
module tb_lsu_store_buffer;
  import lsu_pkg::*;

  localparam int DEPTH = 4;
`ifdef LSU_STB_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic [2:0]  mem_sel;
  logic        flush;
  logic [2:0]  count;
  logic        empty;
  logic        full;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_be;

  int n_cmp  = 0;
  int n_fail = 0;

  stb_entry_t q[$];

  lsu_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .st_valid_i  (st_valid),
    .st_ready_o  (st_ready),
    .st_addr_i   (st_addr),
    .st_data_i   (st_data),
    .st_be_i     (st_be),
    .mem_valid_o (mem_valid),
    .mem_ready_i (mem_ready),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .mem_be_o    (mem_be),
    .mem_sel_o   (mem_sel),
    .flush_i     (flush),
    .count_o     (count),
    .empty_o     (empty),
    .full_o      (full),
    .ld_valid_i  (ld_valid),
    .ld_addr_i   (ld_addr),
    .fwd_hit_o   (fwd_hit),
    .fwd_data_o  (fwd_data),
    .fwd_be_o    (fwd_be)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, sv;
    logic [31:0] sa, sd;
    logic [3:0]  sb;
    logic        mr, fl, lv;
    logic [31:0] la;
    int          e_count;
    logic        e_valid, e_ready;
    logic [31:0] e_data;
    logic [2:0]  e_sel;
    logic        e_hit;
    logic [3:0]  e_fbe;
    logic [31:0] e_fdata;
  } vec_t;

  vec_t vecs [30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 60)
        $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: queue of pending stores, oldest at index 0.
  task automatic model_check();
    stb_entry_t  h;
    logic [31:0] f_data;
    logic [3:0]  f_be;
    int          n;
    n = q.size();
    h = '0;
    if (n > 0) h = q[0];
    f_data = '0;
    f_be   = '0;
    if (FWD_ON && ld_valid) begin
      foreach (q[i]) begin
        if (q[i].addr[31:2] == ld_addr[31:2]) begin
          for (int b = 0; b < 4; b++) begin
            if (q[i].be[b]) begin
              f_data[8*b +: 8] = q[i].data[8*b +: 8];
              f_be[b]          = 1'b1;
            end
          end
        end
      end
    end
    chk("m_count", 32'(count), 32'(n));
    chk("m_empty", 32'(empty), 32'(n == 0));
    chk("m_full", 32'(full), 32'(n == DEPTH));
    chk("m_st_ready", 32'(st_ready), 32'((n < DEPTH) && !flush));
    chk("m_mem_valid", 32'(mem_valid), 32'(n != 0));
    chk("m_mem_addr", mem_addr, h.addr);
    chk("m_mem_data", mem_data, h.data);
    chk("m_mem_be", 32'(mem_be), 32'(h.be));
    chk("m_mem_sel", 32'(mem_sel), 32'((h.addr / 4) % 8));
    chk("m_fwd_hit", 32'(fwd_hit), 32'(f_be != 0));
    chk("m_fwd_be", 32'(fwd_be), 32'(f_be));
    chk("m_fwd_data", fwd_data, f_data);
  endtask

  task automatic model_edge();
    bit do_push;
    bit do_pop;
    do_push = st_valid && (q.size() < DEPTH);
    do_pop  = mem_ready && (q.size() > 0);
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{addr: st_addr, data: st_data, be: st_be});
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input vec_t v);
    rst_n     = v.rst_n;
    st_valid  = v.sv;
    st_addr   = v.sa;
    st_data   = v.sd;
    st_be     = v.sb;
    mem_ready = v.mr;
    flush     = v.fl;
    ld_valid  = v.lv;
    ld_addr   = v.la;
  endtask

  initial begin
    // rst_n sv sa sd sb mr fl lv la | count valid ready data sel | hit fbe fdata
    vecs[0]  = '{1,1,'h14,'hDEADBEEF,'hF,0,0,0,0,   0,0,1,0,0,           0,0,0};
    vecs[1]  = '{1,0,0,0,0,0,0,0,0,                 1,1,1,'hDEADBEEF,5,  0,0,0};
    vecs[2]  = '{1,0,0,0,0,0,1,0,0,                 1,1,0,'hDEADBEEF,5,  0,0,0};
    vecs[3]  = '{1,1,'h20,'h11111111,'hF,0,0,0,0,   0,0,1,0,0,           0,0,0};
    vecs[4]  = '{1,1,'h24,'h22222222,'hF,0,0,0,0,   1,1,1,'h11111111,0,  0,0,0};
    vecs[5]  = '{1,1,'h28,'h33333333,'hF,0,0,0,0,   2,1,1,'h11111111,0,  0,0,0};
    vecs[6]  = '{1,1,'h2C,'h44444444,'hF,0,0,0,0,   3,1,1,'h11111111,0,  0,0,0};
    vecs[7]  = '{1,1,'h30,'h55555555,'hF,0,0,0,0,   4,1,0,'h11111111,0,  0,0,0};
    vecs[8]  = '{1,1,'h30,'h55555555,'hF,1,0,0,0,   4,1,0,'h11111111,0,  0,0,0};
    vecs[9]  = '{1,0,0,0,0,1,0,0,0,                 3,1,1,'h22222222,1,  0,0,0};
    vecs[10] = '{1,0,0,0,0,1,0,0,0,                 2,1,1,'h33333333,2,  0,0,0};
    vecs[11] = '{1,0,0,0,0,1,0,0,0,                 1,1,1,'h44444444,3,  0,0,0};
    vecs[12] = '{1,1,'h40,'hC1C1C1C1,'hF,0,0,0,0,   0,0,1,0,0,           0,0,0};
    vecs[13] = '{1,1,'h44,'hC2C2C2C2,'hF,0,0,0,0,   1,1,1,'hC1C1C1C1,0,  0,0,0};
    vecs[14] = '{1,1,'h48,'hC3C3C3C3,'hF,1,0,0,0,   2,1,1,'hC1C1C1C1,0,  0,0,0};
    vecs[15] = '{1,1,'h4C,'hC4C4C4C4,'hF,1,0,0,0,   2,1,1,'hC2C2C2C2,1,  0,0,0};
    vecs[16] = '{1,1,'h50,'hC5C5C5C5,'hF,1,0,0,0,   2,1,1,'hC3C3C3C3,2,  0,0,0};
    vecs[17] = '{1,1,'h54,'hC6C6C6C6,'hF,1,0,0,0,   2,1,1,'hC4C4C4C4,3,  0,0,0};
    vecs[18] = '{1,1,'h58,'hC7C7C7C7,'hF,1,0,0,0,   2,1,1,'hC5C5C5C5,4,  0,0,0};
    vecs[19] = '{1,1,'h5C,'hC8C8C8C8,'hF,1,0,0,0,   2,1,1,'hC6C6C6C6,5,  0,0,0};
    vecs[20] = '{1,1,'h60,'hC9C9C9C9,'hF,0,0,0,0,   2,1,1,'hC7C7C7C7,6,  0,0,0};
    vecs[21] = '{1,1,'h64,'hDDDDDDDD,'hF,0,1,0,0,   3,1,0,'hC7C7C7C7,6,  0,0,0};
    vecs[22] = '{1,1,'h100,'h11223344,'h3,0,0,0,0,  0,0,1,0,0,           0,0,0};
    vecs[23] = '{1,1,'h100,'hAABBCCDD,'h2,0,0,1,'h102, 1,1,1,'h11223344,0, 1,'h3,'h00003344};
    vecs[24] = '{1,0,0,0,0,0,0,1,'h102,             2,1,1,'h11223344,0,  1,'h3,'h0000CC44};
    vecs[25] = '{1,0,0,0,0,0,0,1,'h104,             2,1,1,'h11223344,0,  0,0,0};
    vecs[26] = '{1,1,'h104,'h55667788,'hF,0,0,0,'h100, 2,1,1,'h11223344,0, 0,0,0};
    vecs[27] = '{0,1,'h200,'h12345678,'hF,0,0,1,'h104, 3,1,1,'h11223344,0, 1,'hF,'h55667788};
    vecs[28] = '{1,0,0,0,0,0,0,1,'h100,             0,0,1,0,0,           0,0,0};
    vecs[29] = '{1,0,0,0,0,0,0,1,'h104,             0,0,1,0,0,           0,0,0};

    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    mem_ready = 1'b0; flush = 1'b0; ld_valid = 1'b0; ld_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_st_ready", 32'(st_ready), 1);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_mem_sel", 32'(mem_sel), 0);
    chk("rst_fwd_hit", 32'(fwd_hit), 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 30; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].e_count == 0));
      chk($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_count == DEPTH));
      chk($sformatf("v%0d_mem_valid", i), 32'(mem_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_st_ready", i), 32'(st_ready), 32'(vecs[i].e_ready));
      chk($sformatf("v%0d_mem_data", i), mem_data, vecs[i].e_data);
      chk($sformatf("v%0d_mem_sel", i), 32'(mem_sel), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d_fwd_hit", i), 32'(fwd_hit), FWD_ON ? 32'(vecs[i].e_hit) : 0);
      chk($sformatf("v%0d_fwd_be", i), 32'(fwd_be), FWD_ON ? 32'(vecs[i].e_fbe) : 0);
      chk($sformatf("v%0d_fwd_data", i), fwd_data, FWD_ON ? vecs[i].e_fdata : 0);
      model_check();
      @(posedge clk);
      model_edge();
      #1;
    end

    // Randomized traffic over a small address pool so forwarding matches are frequent.
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      st_valid  = ($urandom_range(0, 3) != 0);
      st_addr   = 32'h100 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      st_data   = $urandom;
      st_be     = 4'($urandom_range(0, 15));
      mem_ready = ($urandom_range(0, 2) != 0);
      ld_valid  = ($urandom_range(0, 3) != 0);
      ld_addr   = 32'h100 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_store_buffer.md
# lsu_store_buffer

In-order store buffer for the load-store unit. Accepts committed stores over a valid/ready handshake, holds up to DEPTH entries, and drains the oldest entry one per cycle to the bank-write stage. That stage's 1-to-8 demultiplexer consumes `mem_data_o` and `mem_sel_o` as its data and select inputs. Optional store-to-load forwarding lets younger loads read pending store bytes.

## Interface
Parameters:
- `DEPTH`, 4: number of entries. Power of two, 2..16.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, synchronous, active-low.
- `st_valid_i` in 1: store request valid.
- `st_ready_o` out 1: buffer can accept a store.
- `st_addr_i` in 32: store byte address. Word-aligned use only; bits [1:0] ignored.
- `st_data_i` in 32: store data.
- `st_be_i` in 4: byte enables.
- `mem_valid_o` out 1: head entry presented downstream.
- `mem_ready_i` in 1: downstream accepts head entry.
- `mem_addr_o` out 32: head address.
- `mem_data_o` out 32: head data.
- `mem_be_o` out 4: head byte enables.
- `mem_sel_o` out 3: bank select, equal to head address[4:2].
- `flush_i` in 1: discard all entries.
- `count_o` out $clog2(DEPTH)+1: occupancy.
- `empty_o` out 1; `full_o` out 1.
- `ld_valid_i` in 1; `ld_addr_i` in 32: load forwarding query.
- `fwd_hit_o` out 1; `fwd_data_o` out 32; `fwd_be_o` out 4: forwarding result.

## Operation
- Circular FIFO with write pointer, read pointer and count registers. Occupancy state is EMPTY (count=0), PARTIAL, or FULL (count=DEPTH), derived from count.
- Push occurs when `st_valid_i & st_ready_o`.
  - `st_ready_o = ~full_o & ~flush_i`.
  - No write-through when full.
- Pop occurs when `mem_valid_o & mem_ready_i`. `mem_valid_o = ~empty_o`.
- Simultaneous push and pop: both pointers advance and count is unchanged. Allowed in PARTIAL only, since FULL blocks push and EMPTY has no pop.
- Pointers wrap modulo DEPTH. Count never exceeds DEPTH or goes below 0.
- `mem_addr_o`, `mem_data_o`, `mem_be_o` and `mem_sel_o` come from the head entry. They are forced to 0 when empty.
- `flush_i`: at the next edge, count and both pointers go to 0. Flush takes priority over any push or pop in the same cycle; a pop handshake in that cycle is still considered consumed downstream.
- Forwarding (when compiled in), active when `ld_valid_i`:
  - Compare `ld_addr_i[31:2]` against every valid entry's addr[31:2].
  - For each byte lane, take data from the youngest matching entry with that lane enabled.
  - `fwd_be_o` is the OR of lane enables over all matches. `fwd_hit_o = |fwd_be_o`.
  - Lanes not covered output 0.
  - The check is combinational over current contents; same-cycle pushes are not visible and same-cycle pops are still visible.

## Timing
- Reset (`rst_ni` low at a clock edge): count=0 and pointers=0.
  - Outputs after reset: `mem_valid_o`=0, all `mem_*` data outputs=0, `empty_o`=1, `full_o`=0, `count_o`=0, `st_ready_o`=1, all `fwd_*`=0.
  - Entry payload storage is not reset.
- Push-to-visible latency: 1 cycle. An entry pushed at edge N drives `mem_valid_o` after edge N.
- Throughput: one push and one pop per cycle.
- Reset mid-operation drops all entries, identical to flush.
- Forwarding outputs are combinational, zero-cycle, and valid in the same cycle as `ld_valid_i`.

## Configuration
- Macro: `LSU_STB_FWD_EN`.
- Defined: forwarding logic is present as described.
- Undefined: forwarding ports remain on the interface with inputs ignored; `fwd_hit_o`, `fwd_data_o` and `fwd_be_o` are tied to 0.

## Structure
- Shared package `lsu_pkg` holds:
  - `stb_entry_t` packed struct: addr[31:0], data[31:0], be[3:0].
  - `LSU_BANK_SEL_W`=3, `LSU_BANK_SEL_LSB`=2.
- Sub-module `lsu_stb_fwd_merge`:
  - Takes the entry array, valid mask, age order (read pointer) and load address.
  - Returns hit, data and byte enables.
  - Instantiated only under `LSU_STB_FWD_EN`.

## Test plan
- Reset, then push addr 0x0000_0014, data 0xDEAD_BEEF, be 0xF; hold `mem_ready_i`=0.
  - Next cycle: `mem_valid_o`=1, `mem_sel_o`=5, `count_o`=1.
- Push 4 entries (DEPTH=4) with `mem_ready_i`=0.
  - `full_o`=1, `st_ready_o`=0. A 5th `st_valid_i` is held and not accepted.
  - Raise `mem_ready_i`: entries drain in push order, one per cycle.
- Push and pop in the same cycle at count=2, repeated 6 times.
  - Count stays 2 throughout, pointers wrap, and data order is preserved.
- `flush_i` at count=3 with a concurrent `st_valid_i`.
  - Next cycle: count=0, `empty_o`=1, and the store is not accepted.
- Forwarding: push 0x100/0x1122_3344/be 0x3, then 0x100/0xAABB_CCDD/be 0x2, then query 0x102.
  - Response: `fwd_hit_o`=1, `fwd_be_o`=0x3, `fwd_data_o`=0x0000_CC44.
- Assert `rst_ni`=0 for one edge at count=3.
  - All outputs return to their reset values.
